// File: rtl/un_striping_pkg.sv
// Shared constants and helpers for the striping / un-striping lane logic.
// The lane-count clamp is also used on the transmit (striping) side.
package un_striping_pkg;

  localparam int UNSTRIPE_WIDTH = 32;
  localparam int UNSTRIPE_LANES = 4;
  localparam int UNSTRIPE_DEPTH = 4;

  // 0 or an over-range request both mean "use every physical lane".
  function automatic int clamp_lanes(input int requested, input int max_lanes);
    return (requested < 1 || requested > max_lanes) ? max_lanes : requested;
  endfunction

endpackage

// File: rtl/un_striping_nlane_if.sv
// Lane-input / recombined-output bus of the N-lane unstriper.
// master = receive path + downstream consumer, slave = unstriper.
interface un_striping_nlane_if
  import un_striping_pkg::*;
#(
  parameter int WIDTH     = UNSTRIPE_WIDTH,
  parameter int NUM_LANES = UNSTRIPE_LANES
);

  logic [NUM_LANES*WIDTH-1:0] lane_data;
  logic [NUM_LANES-1:0]       lane_valid;
  logic                       out_ready;
  logic [WIDTH-1:0]           data_out;
  logic                       valid_out;

  modport master (
    output lane_data, lane_valid, out_ready,
    input  data_out, valid_out
  );

  modport slave (
    input  lane_data, lane_valid, out_ready,
    output data_out, valid_out
  );

endinterface

// File: rtl/un_striping_fifo.sv
// Per-lane synchronous FIFO with combinational head; full/empty are derived
// from an occupancy count so pointer wrap never aliases full with empty.
module un_striping_fifo
  import un_striping_pkg::*;
#(
  parameter int WIDTH = UNSTRIPE_WIDTH,
  parameter int DEPTH = UNSTRIPE_DEPTH
) (
  input  logic             clk_2f,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  // A pop frees the slot the same-cycle push needs, so full+pop still accepts.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: storage is deliberately not reset; count decides which entries are live.
  always_ff @(posedge clk_2f) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  assign dout  = mem[rptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/un_striping_nlane.sv
// N-lane unstriper: per-lane FIFOs absorb skew, a strict round-robin pointer
// drains them into one registered output with downstream backpressure.
module un_striping_nlane
  import un_striping_pkg::*;
#(
  parameter int  WIDTH     = UNSTRIPE_WIDTH,
  parameter int  NUM_LANES = UNSTRIPE_LANES,
  parameter int  DEPTH     = UNSTRIPE_DEPTH,
  localparam int LW        = $clog2(NUM_LANES) + 1
) (
  input  logic                 clk_2f,
  input  logic                 reset,
  un_striping_nlane_if.slave   bus,
  input  logic [LW-1:0]        active_lanes,
  output logic [NUM_LANES-1:0] lane_full,
  output logic [NUM_LANES-1:0] overflow_err,
  output logic                 idle
);

  localparam int RW = $clog2(NUM_LANES);

  logic [LW-1:0]        cur_lanes;
  logic [LW-1:0]        lanes_req;
  logic [RW-1:0]        rr;
  logic [LW-1:0]        rr_inc;
  logic [NUM_LANES-1:0] push, pop, empty, full, overflow_set;
  logic [WIDTH-1:0]     head [NUM_LANES];
  logic                 load;

  assign lanes_req = LW'(clamp_lanes(int'(active_lanes), NUM_LANES));

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic in_use;

    assign in_use          = LW'(i) < cur_lanes;
    assign pop[i]          = load && (rr == RW'(i));
    assign push[i]         = bus.lane_valid[i] && in_use && (!full[i] || pop[i]);
    assign overflow_set[i] = bus.lane_valid[i] && in_use && full[i] && !pop[i];

    un_striping_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_2f (clk_2f),
      .reset  (reset),
      .push   (push[i]),
      .pop    (pop[i]),
      .din    (bus.lane_data[i*WIDTH +: WIDTH]),
      .dout   (head[i]),
      .empty  (empty[i]),
      .full   (full[i])
    );
  end

  // Never skip an empty lane: stalling on FIFO[rr] is what preserves word order.
  assign load      = (!bus.valid_out || bus.out_ready) && !empty[rr];
  assign rr_inc    = {1'b0, rr} + LW'(1);
  assign idle      = (&empty) && !bus.valid_out;
  assign lane_full = full;

  // NOTE: all state here uses non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      bus.data_out  <= '0;
      bus.valid_out <= 1'b0;
      rr            <= '0;
      cur_lanes     <= lanes_req;
      overflow_err  <= '0;
    end else begin
      overflow_err <= overflow_err | overflow_set;

      if (load) begin
        bus.data_out  <= head[rr];
        bus.valid_out <= 1'b1;
      end else if (bus.out_ready) begin
        bus.valid_out <= 1'b0;
      end

      // Lane mode is only re-sampled between bursts, restarting from lane 0.
      if (idle) begin
        rr        <= '0;
        cur_lanes <= lanes_req;
      end else if (load) begin
        rr <= (rr_inc == cur_lanes) ? '0 : rr_inc[RW-1:0];
      end
    end
  end

endmodule
